// File: rtl/dcf77_pkg.sv
// Shared types and default thresholds for the DCF77 pulse decoder.
package dcf77_pkg;

    // Decoder FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } dcf_state_e;

    // Default thresholds, all in enable ticks (nominal 1 ms).
    localparam int unsigned DefGlitch  = 3;
    localparam int unsigned DefZeroMin = 60;
    localparam int unsigned DefZeroMax = 140;
    localparam int unsigned DefOneMin  = 160;
    localparam int unsigned DefOneMax  = 260;
    localparam int unsigned DefGapMin  = 1500;
    localparam int unsigned DefLossMax = 2500;
    localparam int unsigned DefCntW    = 12;

    // Bits per minute frame (seconds 0..58) and width of the bit index.
    localparam int unsigned FRAME_BITS = 59;
    localparam int unsigned IdxW       = 6;

    // Inclusive range test used by the width classifier.
    function automatic logic in_range(input int unsigned val, input int unsigned lo,
                                      input int unsigned hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/dcf_pulse_decoder_if.sv
// Bundles the tick/receiver inputs and the decoded bit/frame outputs of the decoder.
interface dcf_pulse_decoder_if;

    logic                               enable_in;
    logic                               dcf_in;
    logic                               bit_valid;
    logic                               bit_value;
    logic [dcf77_pkg::IdxW-1:0]         bit_index;
    logic                               minute_start;
    logic                               frame_valid;
    logic [dcf77_pkg::FRAME_BITS-1:0]   frame_data;
    logic                               error;
    logic                               signal_lost;

    // Decoder side: consumes tick and receiver level, produces decode results.
    modport master (
        input  enable_in,
        input  dcf_in,
        output bit_valid,
        output bit_value,
        output bit_index,
        output minute_start,
        output frame_valid,
        output frame_data,
        output error,
        output signal_lost
    );

    // Environment side: drives tick and receiver level, observes results.
    modport slave (
        output enable_in,
        output dcf_in,
        input  bit_valid,
        input  bit_value,
        input  bit_index,
        input  minute_start,
        input  frame_valid,
        input  frame_data,
        input  error,
        input  signal_lost
    );

endinterface

// File: rtl/dcf_glitch_filter.sv
// Two-flop synchronizer followed by a tick-sampled persistence filter:
// the output level only follows the input after GLITCH consecutive ticks at the new level.
module dcf_glitch_filter #(
    parameter int unsigned GLITCH = 3
) (
    input  logic clock_5,
    input  logic reset,
    input  logic enable_in,
    input  logic din,
    output logic dout
);

    localparam int unsigned RunW = (GLITCH > 1) ? $clog2(GLITCH) : 1;
    localparam logic [RunW-1:0] RunLast = RunW'(GLITCH - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [RunW-1:0] run_q, run_d;

    // Synchronizer runs every clock; it carries no state worth resetting.
    always_ff @(posedge clock_5) begin
        sync1_q <= din;
        sync2_q <= sync1_q;
    end

    // Count consecutive ticks disagreeing with the current level; flip on the last one.
    always_comb begin
        level_d = level_q;
        run_d   = run_q;
        if (enable_in) begin
            if (sync2_q != level_q) begin
                if (run_q == RunLast) begin
                    level_d = ~level_q;
                    run_d   = '0;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end else begin
                run_d = '0;
            end
        end
    end

    // Filter state register.
    always_ff @(posedge clock_5) begin
        if (reset) begin
            level_q <= 1'b0;
            run_q   <= '0;
        end else begin
            level_q <= level_d;
            run_q   <= run_d;
        end
    end

    assign dout = level_q;

endmodule

// File: rtl/dcf_pulse_decoder.sv
// DCF77 pulse decoder: measures filtered pulse widths, classifies seconds as 0/1,
// spots the missing-second minute marker and assembles the 59-bit minute frame.
module dcf_pulse_decoder
    import dcf77_pkg::*;
#(
    parameter int unsigned GLITCH   = DefGlitch,
    parameter int unsigned ZERO_MIN = DefZeroMin,
    parameter int unsigned ZERO_MAX = DefZeroMax,
    parameter int unsigned ONE_MIN  = DefOneMin,
    parameter int unsigned ONE_MAX  = DefOneMax,
    parameter int unsigned GAP_MIN  = DefGapMin,
    parameter int unsigned LOSS_MAX = DefLossMax,
    parameter int unsigned CNT_W    = DefCntW
) (
    input logic                 clock_5,
    input logic                 reset,
    dcf_pulse_decoder_if.master bus
);

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [IdxW-1:0]  LastIdx = IdxW'(FRAME_BITS);

    logic filt;
    logic filt_prev_q, filt_prev_d;
    logic rise, fall;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_zero, is_one, gap_ok, loss_hit;

    dcf_state_e state_q, state_d;

    logic bit_valid_q, bit_valid_d;
    logic bit_value_q, bit_value_d;
    logic minute_start_q, minute_start_d;
    logic error_q, error_d;
    logic signal_lost_q, signal_lost_d;
    logic lost_set, lost_clr;

    logic [IdxW-1:0]       bit_index_q, bit_index_d;
    logic [FRAME_BITS-1:0] shadow_q, shadow_d;
    logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
    logic                  frame_valid_q, frame_valid_d;

    dcf_glitch_filter #(
        .GLITCH(GLITCH)
    ) u_filter (
        .clock_5  (clock_5),
        .reset    (reset),
        .enable_in(bus.enable_in),
        .din      (bus.dcf_in),
        .dout     (filt)
    );

    assign rise = filt & ~filt_prev_q;
    assign fall = ~filt & filt_prev_q;

    // Width counter: restart on any filtered edge (a coincident tick is dropped), else count ticks.
    always_comb begin
        filt_prev_d = filt;
        cnt_d       = cnt_q;
        if (rise || fall) begin
            cnt_d = '0;
        end else if (bus.enable_in && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign is_zero  = in_range(32'(cnt_q), ZERO_MIN, ZERO_MAX);
    assign is_one   = in_range(32'(cnt_q), ONE_MIN, ONE_MAX);
    assign gap_ok   = 32'(cnt_q) >= GAP_MIN;
    assign loss_hit = 32'(cnt_q) >= LOSS_MAX;

    // FSM state register.
    always_ff @(posedge clock_5) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a rise in LOW takes priority over the loss timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (rise) state_d = StHigh;
            StHigh: if (fall) state_d = StLow;
            StLow: begin
                if (rise) begin
                    state_d = StHigh;
                end else if (loss_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: next values of the registered one-clock pulses and the loss flag.
    always_comb begin
        bit_valid_d    = 1'b0;
        bit_value_d    = 1'b0;
        minute_start_d = 1'b0;
        error_d        = 1'b0;
        lost_set       = 1'b0;
        lost_clr       = 1'b0;
        unique case (state_q)
            StIdle: if (rise) lost_clr = 1'b1;
            StHigh: begin
                if (fall) begin
                    if (is_zero) begin
                        bit_valid_d = 1'b1;
                    end else if (is_one) begin
                        bit_valid_d = 1'b1;
                        bit_value_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StLow: begin
                if (rise) begin
                    minute_start_d = gap_ok;
                end else if (loss_hit) begin
                    error_d  = 1'b1;
                    lost_set = 1'b1;
                end
            end
            default: ;
        endcase
        signal_lost_d = lost_set | (signal_lost_q & ~lost_clr);
    end

    // Frame assembly: a marker publishes a complete shadow and restarts; bits past 59 are dropped.
    always_comb begin
        bit_index_d   = bit_index_q;
        shadow_d      = shadow_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        if (minute_start_d) begin
            if (bit_index_q == LastIdx) begin
                frame_data_d  = shadow_q;
                frame_valid_d = 1'b1;
            end
            bit_index_d = '0;
            shadow_d    = '0;
        end else if (bit_valid_d && (bit_index_q < LastIdx)) begin
            shadow_d[bit_index_q] = bit_value_d;
            bit_index_d           = bit_index_q + 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock_5) begin
        if (reset) begin
            filt_prev_q    <= 1'b0;
            cnt_q          <= '0;
            bit_valid_q    <= 1'b0;
            bit_value_q    <= 1'b0;
            minute_start_q <= 1'b0;
            error_q        <= 1'b0;
            signal_lost_q  <= 1'b0;
            bit_index_q    <= '0;
            shadow_q       <= '0;
            frame_data_q   <= '0;
            frame_valid_q  <= 1'b0;
        end else begin
            filt_prev_q    <= filt_prev_d;
            cnt_q          <= cnt_d;
            bit_valid_q    <= bit_valid_d;
            bit_value_q    <= bit_value_d;
            minute_start_q <= minute_start_d;
            error_q        <= error_d;
            signal_lost_q  <= signal_lost_d;
            bit_index_q    <= bit_index_d;
            shadow_q       <= shadow_d;
            frame_data_q   <= frame_data_d;
            frame_valid_q  <= frame_valid_d;
        end
    end

    assign bus.bit_valid    = bit_valid_q;
    assign bus.bit_value    = bit_value_q;
    assign bus.bit_index    = bit_index_q;
    assign bus.minute_start = minute_start_q;
    assign bus.frame_valid  = frame_valid_q;
    assign bus.frame_data   = frame_data_q;
    assign bus.error        = error_q;
    assign bus.signal_lost  = signal_lost_q;

endmodule
